// File: rtl/cla_bist_ctrl_if.sv
// Operand/result and control bundle between a cla_bist_ctrl and the
// environment around it. master = controller side, slave = stimulus/adder side.
interface cla_bist_ctrl_if #(
  parameter int WIDTH = 6,
  parameter int ERR_W = 16
);
  logic                 i_start;
  logic                 i_mode;
  logic [2*WIDTH-1:0]   i_seed;
  logic [2*WIDTH-1:0]   i_num_vec;
  logic [WIDTH-1:0]     o_add1;
  logic [WIDTH-1:0]     o_add2;
  logic [WIDTH:0]       i_result;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_pass;
  logic [ERR_W-1:0]     o_err_cnt;
  logic [3*WIDTH:0]     o_fail_vec;

  modport master (
    input  i_start, i_mode, i_seed, i_num_vec, i_result,
    output o_add1, o_add2, o_busy, o_done, o_pass, o_err_cnt, o_fail_vec
  );

  modport slave (
    output i_start, i_mode, i_seed, i_num_vec, i_result,
    input  o_add1, o_add2, o_busy, o_done, o_pass, o_err_cnt, o_fail_vec
  );
endinterface

// File: rtl/cla_bist_ctrl.sv
// BIST sequencer for one cla_Nbit adder: exhaustive or Galois-LFSR operand sweep.
// Optional BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module cla_bist_ctrl #(
  parameter int                 WIDTH      = 6,
  parameter int                 SETTLE_CYC = 1,
  parameter int                 ERR_W      = 16,
  parameter logic [2*WIDTH-1:0] LFSR_TAPS  = (2*WIDTH)'('h053)
)(
  input  logic            i_clk,
  input  logic            i_rst_n,
  cla_bist_ctrl_if.master io_bus
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = VW + 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);

  // States: IDLE wait start | SETTLE hold operands | CHECK compare, step | DONE report
  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic [VW-1:0]      r_vec;
  logic [CW-1:0]      r_vec_rem;
  logic [SW-1:0]      r_settle;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [3*WIDTH:0]   r_fail_vec;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_expected;
  logic               w_mismatch;
  logic               w_last;
  logic               w_end;
  logic               w_err_sat;
  logic [VW-1:0]      w_lfsr_next;
  logic [VW-1:0]      w_vec_next;
  logic [VW-1:0]      w_seed;
  logic [CW-1:0]      w_num_vec;

  assign w_a        = r_vec[VW-1:WIDTH];
  assign w_b        = r_vec[WIDTH-1:0];
  assign w_expected = {1'b0, w_a} + {1'b0, w_b};
  assign w_mismatch = (io_bus.i_result != w_expected);
  assign w_last     = (r_vec_rem == CW'(1));
  assign w_err_sat  = &r_err_cnt;

  assign w_lfsr_next = {r_vec[VW-2:0], 1'b0} ^ (r_vec[VW-1] ? LFSR_TAPS : '0);
  assign w_vec_next  = r_mode ? w_lfsr_next : r_vec + VW'(1);
  assign w_seed      = (io_bus.i_seed == '0) ? VW'(1) : io_bus.i_seed;
  // Full sweep length 2^VW needs the extra bit; a zero count also means full sweep.
  assign w_num_vec   = (io_bus.i_mode && io_bus.i_num_vec != '0) ?
                       {1'b0, io_bus.i_num_vec} : {1'b1, {VW{1'b0}}};

`ifdef BIST_STOP_ON_FAIL_EN
  assign w_end = w_last || w_mismatch;
`else
  assign w_end = w_last;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_vec      <= '0;
      r_vec_rem  <= '0;
      r_settle   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_fail_vec <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (io_bus.i_start) begin
            r_mode     <= io_bus.i_mode;
            r_vec      <= io_bus.i_mode ? w_seed : '0;
            r_vec_rem  <= w_num_vec;
            r_settle   <= SW'(SETTLE_CYC);
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle == SW'(1)) begin
            r_state <= S_CHECK;
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (!w_err_sat) begin
              r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
            if (r_err_cnt == '0) begin
              r_fail_vec <= {w_a, w_b, io_bus.i_result};
            end
          end
          if (w_end) begin
            r_state <= S_DONE;
          end else begin
            r_vec     <= w_vec_next;
            r_vec_rem <= r_vec_rem - CW'(1);
            r_settle  <= SW'(SETTLE_CYC);
            r_state   <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (r_err_cnt == '0);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.o_add1     = w_a;
  assign io_bus.o_add2     = w_b;
  assign io_bus.o_busy     = r_busy;
  assign io_bus.o_done     = r_done;
  assign io_bus.o_pass     = r_pass;
  assign io_bus.o_err_cnt  = r_err_cnt;
  assign io_bus.o_fail_vec = r_fail_vec;

endmodule

// File: tb/tb_cla_bist_ctrl.sv
// Bench for cla_bist_ctrl: stand-in adders (correct, bit-6 stuck, delayed, random
// fault) around two controllers, checked against a sweep model kept here.
module tb_cla_bist_ctrl;
  localparam int W  = 6;
  localparam int S  = 1;
  localparam int S3 = 3;
  localparam int EW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cla_bist_ctrl_if #(.WIDTH(W), .ERR_W(EW)) bus  ();
  cla_bist_ctrl_if #(.WIDTH(W), .ERR_W(EW)) bus3 ();

  cla_bist_ctrl #(.WIDTH(W), .SETTLE_CYC(S),  .ERR_W(EW)) dut  (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));
  cla_bist_ctrl #(.WIDTH(W), .SETTLE_CYC(S3), .ERR_W(EW)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus3));

  int          n_chk = 0;
  int          n_err = 0;
  int          fault_sel = 0;
  logic [11:0] f_mask = '0;
  logic [6:0]  f_flip = '0;

  // sel: 0 correct, 1 sum bit 6 stuck at 0, 2 two-cycle registered delay, 3 flip on pattern
  function automatic logic [6:0] adder_model(input int sel, input logic [5:0] a, input logic [5:0] b,
                                             input logic [11:0] m, input logic [6:0] flip);
    logic [6:0] sum;
    sum = 7'(a) + 7'(b);
    if (sel == 1) sum[6] = 1'b0;
    if (sel == 3 && (({a, b} & m) == m)) sum = sum ^ flip;
    return sum;
  endfunction

  logic [6:0] d1, d2, e1, e2;
  always @(posedge clk) begin
    d1 <= 7'(bus.o_add1) + 7'(bus.o_add2);
    d2 <= d1;
    e1 <= 7'(bus3.o_add1) + 7'(bus3.o_add2);
    e2 <= e1;
  end

  always_comb begin
    bus.i_result = adder_model(fault_sel, bus.o_add1, bus.o_add2, f_mask, f_flip);
    if (fault_sel == 2) bus.i_result = d2;
  end
  assign bus3.i_result = e2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference sweep: vector list, error count, first failure
  logic [11:0] ref_vecs[$];
  logic [15:0] ref_err;
  logic [18:0] ref_fail;
  logic        ref_pass;

  task automatic ref_run(input logic mode, input logic [11:0] seed, input logic [11:0] num, input int sel);
    int          n;
    int          v;
    logic [11:0] s;
    logic [5:0]  a, b;
    logic [6:0]  r, good;
    n = (!mode || num == 0) ? 4096 : int'(num);
    s = !mode ? 12'd0 : ((seed == 0) ? 12'd1 : seed);
    ref_vecs.delete();
    ref_err  = '0;
    ref_fail = '0;
    for (int i = 0; i < n; i++) begin
      ref_vecs.push_back(s);
      a = s[11:6];
      b = s[5:0];
      good = 7'(a) + 7'(b);
      r = adder_model(sel, a, b, f_mask, f_flip);
      if (r != good) begin
        if (ref_err == 0) ref_fail = {a, b, r};
        if (ref_err != 16'hffff) ref_err = ref_err + 16'd1;
`ifdef BIST_STOP_ON_FAIL_EN
        break;
`endif
      end
      if (mode) begin
        v = int'(s) * 2;                  // multiply by x modulo x^12+x^6+x^4+x+1
        if (v >= 4096) v = v ^ 'h1053;
        s = 12'(v);
      end else begin
        s = s + 12'd1;
      end
    end
    ref_pass = (ref_err == 0);
  endtask

  task automatic run_main(input string nm, input logic mode, input logic [11:0] seed, input logic [11:0] num,
                          input int sel, input int exp_done, input logic [15:0] exp_err,
                          input logic exp_pass, input logic [18:0] exp_fail);
    int   cyc;
    int   vi;
    logic got;
    fault_sel     = sel;
    bus.i_mode    = mode;
    bus.i_seed    = seed;
    bus.i_num_vec = num;
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    chk({nm, " busy"}, 32'(bus.o_busy), 32'd1);
    cyc = 0; vi = 0; got = 1'b0;
    while (cyc < exp_done + 50) begin
      if (bus.o_done) begin got = 1'b1; break; end
      if (cyc % (S + 1) == 0 && vi < ref_vecs.size()) begin
        chk({nm, " vec"}, 32'({bus.o_add1, bus.o_add2}), 32'(ref_vecs[vi]));
        vi++;
      end
      bus.i_start = (cyc == 5);
      @(negedge clk); cyc++;
    end
    bus.i_start = 1'b0;
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " done_cyc"}, 32'(cyc), 32'(exp_done));
    chk({nm, " vec_count"}, 32'(vi), 32'(ref_vecs.size()));
    chk({nm, " busy_end"}, 32'(bus.o_busy), 32'd0);
    chk({nm, " err_cnt"}, 32'(bus.o_err_cnt), 32'(exp_err));
    chk({nm, " pass"}, 32'(bus.o_pass), 32'(exp_pass));
    if (exp_err != 0) chk({nm, " fail_vec"}, 32'(bus.o_fail_vec), 32'(exp_fail));
    @(negedge clk);
    chk({nm, " done_pulse"}, 32'(bus.o_done), 32'd0);
    @(negedge clk); @(negedge clk);
    chk({nm, " err_hold"}, 32'(bus.o_err_cnt), 32'(exp_err));
    chk({nm, " pass_hold"}, 32'(bus.o_pass), 32'(exp_pass));
  endtask

  typedef struct {
    string       nm;
    logic        mode;
    logic [11:0] seed;
    logic [11:0] num;
    int          sel;
    int          exp_done;
    logic [15:0] exp_err;
    logic        exp_pass;
    logic [18:0] exp_fail;
  } row_t;

  row_t tbl[6];

  initial begin
    int cyc;
    tbl[0] = '{"exh_ok",     1'b0, 12'h000, 12'd0,  0, 8193, 16'd0, 1'b1, 19'd0};
`ifdef BIST_STOP_ON_FAIL_EN
    tbl[1] = '{"exh_bit6",   1'b0, 12'h000, 12'd0,  1, 257,  16'd1, 1'b0, {6'd1, 6'd63, 7'd0}};
`else
    tbl[1] = '{"exh_bit6",   1'b0, 12'h000, 12'd0,  1, 8193, 16'd2016, 1'b0, {6'd1, 6'd63, 7'd0}};
`endif
    tbl[2] = '{"lfsr_seed0", 1'b1, 12'h000, 12'd10, 0, 21,   16'd0, 1'b1, 19'd0};
    tbl[3] = '{"lfsr_one",   1'b1, 12'h5a5, 12'd1,  1, 3,    16'd0, 1'b1, 19'd0};
    tbl[4] = '{"lfsr_max",   1'b1, 12'hfff, 12'd1,  1, 3,    16'd1, 1'b0, {6'd63, 6'd63, 7'd62}};
    tbl[5] = '{"lfsr_full",  1'b1, 12'h001, 12'd0,  0, 8193, 16'd0, 1'b1, 19'd0};

    bus.i_start = 1'b0;  bus.i_mode = 1'b0;  bus.i_seed = '0;  bus.i_num_vec = '0;
    bus3.i_start = 1'b0; bus3.i_mode = 1'b1; bus3.i_seed = '0; bus3.i_num_vec = 12'd10;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(bus.o_busy), 32'd0);
    chk("rst done", 32'(bus.o_done), 32'd0);
    chk("rst pass", 32'(bus.o_pass), 32'd0);
    chk("rst err", 32'(bus.o_err_cnt), 32'd0);
    chk("rst fail_vec", 32'(bus.o_fail_vec), 32'd0);
    chk("rst operands", 32'({bus.o_add1, bus.o_add2}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      ref_run(tbl[i].mode, tbl[i].seed, tbl[i].num, tbl[i].sel);
      run_main(tbl[i].nm, tbl[i].mode, tbl[i].seed, tbl[i].num, tbl[i].sel,
               tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_pass, tbl[i].exp_fail);
    end

    for (int r = 0; r < 20; r++) begin
      logic [11:0] seed, num;
      int          sel;
      seed   = 12'($urandom_range(0, 4095));
      num    = 12'($urandom_range(1, 40));
      sel    = (r % 2 == 0) ? 0 : 3;
      f_mask = 12'((1 << $urandom_range(0, 11)) | (1 << $urandom_range(0, 11)));
      f_flip = 7'($urandom_range(1, 127));
      ref_run(1'b1, seed, num, sel);
      run_main("rnd", 1'b1, seed, num, sel, ref_vecs.size() * (S + 1) + 1,
               ref_err, ref_pass, ref_fail);
    end

    // Delayed adder with too short a settle time must be caught
    fault_sel = 2;
    bus.i_mode = 1'b1; bus.i_seed = '0; bus.i_num_vec = 12'd10;
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    cyc = 0;
    while (cyc < 100 && !bus.o_done) begin @(negedge clk); cyc++; end
    chk("delay_s1 done_seen", 32'(bus.o_done), 32'd1);
    chk("delay_s1 err_nonzero", 32'(bus.o_err_cnt != 0), 32'd1);
    chk("delay_s1 pass", 32'(bus.o_pass), 32'd0);

    // Same delayed adder with three settle cycles passes
    @(negedge clk); bus3.i_start = 1'b1;
    @(negedge clk); bus3.i_start = 1'b0;
    cyc = 0;
    while (cyc < 200 && !bus3.o_done) begin @(negedge clk); cyc++; end
    chk("delay_s3 done_cyc", 32'(cyc), 32'(10 * (S3 + 1) + 1));
    chk("delay_s3 err", 32'(bus3.o_err_cnt), 32'd0);
    chk("delay_s3 pass", 32'(bus3.o_pass), 32'd1);

    // Asynchronous reset in the middle of a failing exhaustive run
    fault_sel = 1;
    bus.i_mode = 1'b0;
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst busy_before", 32'(bus.o_busy), 32'd1);
    chk("midrst err_before", 32'(bus.o_err_cnt != 0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(bus.o_busy), 32'd0);
    chk("midrst err", 32'(bus.o_err_cnt), 32'd0);
    chk("midrst fail_vec", 32'(bus.o_fail_vec), 32'd0);
    chk("midrst operands", 32'({bus.o_add1, bus.o_add2}), 32'd0);
    chk("midrst pass", 32'(bus.o_pass), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    ref_run(1'b1, 12'h000, 12'd10, 0);
    run_main("after_rst", 1'b1, 12'h000, 12'd10, 0, 21, 16'd0, 1'b1, 19'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cla_bist_ctrl.md
Name: cla_bist_ctrl

Overview:
Sequential built-in self-test controller for the generated N-bit adders (cla_Nbit family).
- Drives the adder operand inputs and samples the adder result.
- Compares each result against a behavioural sum and accumulates an error count.
- Sits beside an adder instance in the characterisation wrapper; one controller serves one adder under test (DUT).

Parameters:
WIDTH, 6, adder operand width; the result is WIDTH+1 bits.
SETTLE_CYC, 1, number of cycles operands are held before the result is sampled; must be >= 1.
ERR_W, 16, width of the error counter.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  reset; asynchronous assert, active-low.
i_start  input  1  start request; sampled only in IDLE.
i_mode  input  1  0 = exhaustive sweep, 1 = LFSR sweep.
i_seed  input  2*WIDTH  LFSR seed, loaded on start.
i_num_vec  input  2*WIDTH  vector count for LFSR mode; 0 means 2^(2*WIDTH).
o_add1  output  WIDTH  operand A to DUT i_add1.
o_add2  output  WIDTH  operand B to DUT i_add2.
i_result  input  WIDTH+1  DUT o_result.
o_busy  output  1  high from the first cycle after start is accepted until DONE.
o_done  output  1  one-cycle pulse at the end of a run.
o_pass  output  1  1 if the last completed run had zero errors.
o_err_cnt  output  ERR_W  mismatch count; saturates at all-ones.
o_fail_vec  output  3*WIDTH+1  first failing {A, B, result}; valid when o_err_cnt != 0.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE.
- Reset asserted mid-run: aborts immediately, returns to IDLE, clears the error count and o_fail_vec.

FSM states: IDLE, SETTLE, CHECK, DONE.

IDLE:
- On i_start=1: load vector 0, clear o_err_cnt, o_fail_vec and o_pass, load the settle counter with SETTLE_CYC, go to SETTLE.
- i_start in any other state is ignored.

SETTLE:
- Operands are held stable from registers.
- Decrement the counter each cycle; when it reaches 1, go to CHECK.
- The state lasts exactly SETTLE_CYC cycles.

CHECK (one cycle):
- expected = zero-extended A + zero-extended B, WIDTH+1 bits, no truncation.
- On mismatch: increment o_err_cnt (saturating); if this is the first error, capture {A, B, i_result} into o_fail_vec.
- If this was the last vector, go to DONE.
- Otherwise, in the same edge, drive the next vector, reload the counter and go to SETTLE.

DONE (one cycle):
- o_done=1, o_pass = (o_err_cnt==0), o_busy=0; then go to IDLE.
- o_pass, o_err_cnt and o_fail_vec hold until the next accepted start.

Timing:
- Each vector costs SETTLE_CYC+1 cycles.
- o_done asserts N*(SETTLE_CYC+1)+1 cycles after the start-accept edge (N = vector count).

Exhaustive mode:
- A 2*WIDTH counter with A = upper half and B = lower half, starting at 0.
- N = 2^(2*WIDTH); the run ends after counter value all-ones.

LFSR mode:
- 2*WIDTH Galois LFSR; for WIDTH=6 the polynomial is x^12+x^6+x^4+x+1.
- Vector 0 = seed; a seed of 0 is replaced by 1.
- N = i_num_vec, with 0 meaning 2^(2*WIDTH).

Operands are registered outputs and never change outside the CHECK->SETTLE edge.

Optional Feature:
BIST_STOP_ON_FAIL_EN
- Defined: a mismatch in CHECK records the error (count becomes 1, o_fail_vec captured) and goes directly to DONE. o_pass=0, and the remaining vectors are skipped.
- Undefined: the run always completes all N vectors.

Test Plan:
- Correct adder model, WIDTH=6, SETTLE_CYC=1, i_mode=0, pulse i_start -> o_done after 8193 cycles; o_pass=1, o_err_cnt=0.
- DUT result bit 6 forced to 0, exhaustive run -> o_err_cnt=2016, o_pass=0, o_fail_vec={A=1, B=63, result=0x00}.
- i_mode=1, seed=0, i_num_vec=10 -> first vector A=0, B=1 (seed forced to 1); exactly 10 CHECK cycles; o_done 21 cycles after start-accept.
- Assert i_start again while o_busy=1 -> ignored, vector sequence uninterrupted; drop i_rst_n mid-run -> outputs 0 and FSM in IDLE asynchronously, new start runs cleanly.
- SETTLE_CYC=3, result model with a 2-cycle registered delay -> pass; same model with SETTLE_CYC=1 -> nonzero o_err_cnt.
- BIST_STOP_ON_FAIL_EN defined with the bit-6 fault -> o_done right after the CHECK of vector A=1, B=63; o_err_cnt=1, o_pass=0.
